// File: rtl/fifo_ctrl_fsm.sv
// fifo_ctrl_fsm: control FSM and pointer register bank for the 8-entry FIFO.
// Ports: clk, reset (async, active-high); rd_en/wr_en requests;
//   next_head/next_tail/next_data_count from fifo_cal_addr;
//   state/head/tail/data_count back to fifo_cal_addr;
//   full/empty flags; wr_ack/wr_err/rd_ack/rd_err strobes.
// Optional macro FIFO_ERR_CNT_EN adds rd_err_cnt/wr_err_cnt (saturating).
module fifo_ctrl_fsm #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] next_head,
    input  logic [ADDR_W-1:0] next_tail,
    input  logic [ADDR_W:0]   next_data_count,
    output logic [2:0]        state,
    output logic [ADDR_W-1:0] head,
    output logic [ADDR_W-1:0] tail,
    output logic [ADDR_W:0]   data_count,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
`ifdef FIFO_ERR_CNT_EN
    ,
    output logic [7:0]        rd_err_cnt,
    output logic [7:0]        wr_err_cnt
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_READ     = 3'b001,
        ST_WRITE    = 3'b010,
        ST_RD_ERROR = 3'b011,
        ST_WR_ERROR = 3'b100,
        ST_NO_OP    = 3'b101
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic legal;
    logic wr_only;
    logic rd_only;

    // 110/111 can only appear through upset; recover via INIT.
    assign legal   = (state_q <= ST_NO_OP);
    assign wr_only = wr_en & ~rd_en;
    assign rd_only = rd_en & ~wr_en;

    always_comb begin
        state_d = ST_NO_OP;
        head_d  = next_head;
        tail_d  = next_tail;
        count_d = next_data_count;
        // next_data_count already includes the effect of the current state,
        // so it is the occupancy the new request would act upon.
        unique case (1'b1)
            !legal: begin
                state_d = ST_INIT;
            end
            legal && wr_only: begin
                state_d = (next_data_count == FULL_CNT) ? ST_WR_ERROR
                                                        : ST_WRITE;
            end
            legal && rd_only: begin
                state_d = (next_data_count == '0) ? ST_RD_ERROR : ST_READ;
            end
            default: begin
                state_d = ST_NO_OP;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign state      = state_q;
    assign head       = head_q;
    assign tail       = tail_q;
    assign data_count = count_q;
    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign wr_ack     = (state_q == ST_WRITE);
    assign wr_err     = (state_q == ST_WR_ERROR);
    assign rd_ack     = (state_q == ST_READ);
    assign rd_err     = (state_q == ST_RD_ERROR);

`ifdef FIFO_ERR_CNT_EN
    logic [7:0] rd_err_cnt_q, rd_err_cnt_d;
    logic [7:0] wr_err_cnt_q, wr_err_cnt_d;

    always_comb begin
        rd_err_cnt_d = rd_err_cnt_q;
        wr_err_cnt_d = wr_err_cnt_q;
        if (rd_err && (rd_err_cnt_q != 8'hff)) begin
            rd_err_cnt_d = rd_err_cnt_q + 8'd1;
        end
        if (wr_err && (wr_err_cnt_q != 8'hff)) begin
            wr_err_cnt_d = wr_err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_err_cnt_q <= '0;
            wr_err_cnt_q <= '0;
        end else begin
            rd_err_cnt_q <= rd_err_cnt_d;
            wr_err_cnt_q <= wr_err_cnt_d;
        end
    end

    assign rd_err_cnt = rd_err_cnt_q;
    assign wr_err_cnt = wr_err_cnt_q;
`endif

endmodule
